binom_coef_seq: RTL and testbench

//  Sequencer that computes binomial coefficients C(n,k), k=0..n, for (a+b)^n.

---
 rtl/binom_pkg.sv | 33 +++
 rtl/binom_coef_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_binom_coef_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/binom_pkg.sv
// -----------------------------------------------------------------------------
// binom_pkg
//   Constants shared by the binomial-coefficient sequencer and the 32-bit ALU.
//   - ALU opcodes ALU_AND..ALU_EQ (4-bit, common encoding with the ALU)
//   - sequencer FSM state encoding
// -----------------------------------------------------------------------------
package binom_pkg;

  // ALU opcode map. The ALU decodes exactly these values.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_NOT = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0111;
  localparam logic [3:0] ALU_SHL = 4'b1000;
  localparam logic [3:0] ALU_EQ  = 4'b1001;

  // Sequencer states; one ALU operation per arithmetic state.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    EMIT = 3'd1,
    CMP  = 3'd2,
    SUB  = 3'd3,
    MUL  = 3'd4,
    INC  = 3'd5,
    DIV  = 3'd6,
    DONE = 3'd7
  } binom_state_t;

endpackage : binom_pkg

// File: rtl/binom_coef_seq.sv
// -----------------------------------------------------------------------------
// binom_coef_seq
//   Streams the binomial coefficients C(n,k), k = 0..n, using the external
//   32-bit ALU for every arithmetic step:
//       C(n,k+1) = C(n,k) * (n-k) / (k+1)
//   Each coefficient is offered on a valid/ready port; between two offers the
//   sequencer walks CMP -> SUB -> MUL -> INC -> DIV (one ALU op per cycle).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, n_in         1-cycle request with exponent n (accepted only in IDLE)
//   busy                high in every state except IDLE
//   err                 1-cycle pulse when start carries n_in > N_MAX
//   coef_valid/ready    coefficient handshake; coef_k / coef_out = k / C(n,k)
//   done                1-cycle pulse after C(n,n) has been accepted
//   alu_e1/e2/sel       ALU operands and opcode (registered, no input paths)
//   alu_res, alu_zf     ALU result and zero flag (combinational, same cycle)
//
// All outputs are registers loaded from the next-state/next-register values,
// so they equal a decode of the current state while having no combinational
// path from any input.
// -----------------------------------------------------------------------------
module binom_coef_seq
  import binom_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NW    = 5,
  parameter int N_MAX = 30
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] n_in,
  output logic          busy,
  output logic          err,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic [NW-1:0] coef_k,
  output logic [DW-1:0] coef_out,
  output logic          done,
  output logic [DW-1:0] alu_e1,
  output logic [DW-1:0] alu_e2,
  output logic [3:0]    alu_sel,
  input  logic [DW-1:0] alu_res,
  input  logic          alu_zf
);

  localparam logic [NW-1:0] N_LIMIT = NW'(N_MAX);

  // architectural state
  binom_state_t  state_r, state_s;
  logic [NW-1:0] n_r, n_s;
  logic [NW-1:0] k_r, k_s;
  logic [DW-1:0] c_r, c_s;   // current coefficient C(n,k)
  logic [DW-1:0] t_r, t_s;   // n - k
  logic [DW-1:0] p_r, p_s;   // C(n,k) * (n - k)
  logic          err_s;

  // registered outputs
  logic          busy_r;
  logic          err_r;
  logic          coef_valid_r;
  logic [NW-1:0] coef_k_r;
  logic [DW-1:0] coef_out_r;
  logic          done_r;
  logic [DW-1:0] alu_e1_r, alu_e1_s;
  logic [DW-1:0] alu_e2_r, alu_e2_s;
  logic [3:0]    alu_sel_r, alu_sel_s;

  // Next-state and datapath register update; ALU results are captured here.
  always_comb begin
    state_s = state_r;
    n_s     = n_r;
    k_s     = k_r;
    c_s     = c_r;
    t_s     = t_r;
    p_s     = p_r;
    err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (n_in > N_LIMIT) begin
            err_s = 1'b1;
          end else begin
            n_s     = n_in;
            k_s     = '0;
            c_s     = DW'(1'b1);
            state_s = EMIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (coef_ready) begin
          state_s = CMP;
        end else begin
          state_s = EMIT;
        end
      end
      CMP: begin
        // EQ yields a non-zero result when k == n, i.e. zf low means last term.
        if (!alu_zf) begin
          state_s = DONE;
        end else begin
          state_s = SUB;
        end
      end
      SUB: begin
        t_s     = alu_res;
        state_s = MUL;
      end
      MUL: begin
        p_s     = alu_res;
        state_s = INC;
      end
      INC: begin
        k_s     = alu_res[NW-1:0];
        state_s = DIV;
      end
      DIV: begin
        // k was already incremented, so the divisor is k+1 >= 1 and exact.
        c_s     = alu_res;
        state_s = EMIT;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // ALU operand/opcode decode for the state being entered next cycle.
  always_comb begin
    alu_e1_s  = '0;
    alu_e2_s  = '0;
    alu_sel_s = ALU_AND;
    case (state_s)
      CMP: begin
        alu_e1_s  = DW'(k_s);
        alu_e2_s  = DW'(n_s);
        alu_sel_s = ALU_EQ;
      end
      SUB: begin
        alu_e1_s  = DW'(n_s);
        alu_e2_s  = DW'(k_s);
        alu_sel_s = ALU_SUB;
      end
      MUL: begin
        alu_e1_s  = c_s;
        alu_e2_s  = t_s;
        alu_sel_s = ALU_MUL;
      end
      INC: begin
        alu_e1_s  = DW'(k_s);
        alu_e2_s  = DW'(1'b1);
        alu_sel_s = ALU_ADD;
      end
      DIV: begin
        alu_e1_s  = p_s;
        alu_e2_s  = DW'(k_s);
        alu_sel_s = ALU_DIV;
      end
      default: begin
        alu_e1_s  = '0;
        alu_e2_s  = '0;
        alu_sel_s = ALU_AND;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      n_r     <= '0;
      k_r     <= '0;
      c_r     <= '0;
      t_r     <= '0;
      p_r     <= '0;
    end else begin
      state_r <= state_s;
      n_r     <= n_s;
      k_r     <= k_s;
      c_r     <= c_s;
      t_r     <= t_s;
      p_r     <= p_s;
    end
  end

  // Output registers, loaded from the decode of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      coef_valid_r <= 1'b0;
      coef_k_r     <= '0;
      coef_out_r   <= '0;
      done_r       <= 1'b0;
      alu_e1_r     <= '0;
      alu_e2_r     <= '0;
      alu_sel_r    <= ALU_AND;
    end else begin
      busy_r       <= (state_s != IDLE);
      err_r        <= err_s;
      coef_valid_r <= (state_s == EMIT);
      coef_k_r     <= (state_s == EMIT) ? k_s : '0;
      coef_out_r   <= (state_s == EMIT) ? c_s : '0;
      done_r       <= (state_s == DONE);
      alu_e1_r     <= alu_e1_s;
      alu_e2_r     <= alu_e2_s;
      alu_sel_r    <= alu_sel_s;
    end
  end

  assign busy       = busy_r;
  assign err        = err_r;
  assign coef_valid = coef_valid_r;
  assign coef_k     = coef_k_r;
  assign coef_out   = coef_out_r;
  assign done       = done_r;
  assign alu_e1     = alu_e1_r;
  assign alu_e2     = alu_e2_r;
  assign alu_sel    = alu_sel_r;

endmodule : binom_coef_seq

// File: tb/tb_binom_coef_seq.sv
// -----------------------------------------------------------------------------
// tb_binom_coef_seq
//   Drives binom_coef_seq together with a behavioural 32-bit ALU and checks the
//   coefficient stream against Pascal's triangle built in the bench.
// -----------------------------------------------------------------------------
module tb_binom_coef_seq;
  import binom_pkg::*;

  localparam int DW = 32;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [NW-1:0] n_in = '0;
  logic          busy, err, coef_valid, done;
  logic          coef_ready = 1'b0;
  logic [NW-1:0] coef_k;
  logic [DW-1:0] coef_out, alu_e1, alu_e2, alu_res;
  logic [3:0]    alu_sel;
  logic          alu_zf;

  int tests = 0;
  int fails = 0;
  longint pas [0:31][0:31];

  always #5 clk = ~clk;

  binom_coef_seq #(.DW(DW), .NW(NW), .N_MAX(30)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in),
    .busy(busy), .err(err), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_k(coef_k), .coef_out(coef_out), .done(done),
    .alu_e1(alu_e1), .alu_e2(alu_e2), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zf(alu_zf)
  );

  // behavioural ALU placed beside the sequencer
  always_comb begin
    case (alu_sel)
      ALU_AND: alu_res = alu_e1 & alu_e2;
      ALU_OR:  alu_res = alu_e1 | alu_e2;
      ALU_XOR: alu_res = alu_e1 ^ alu_e2;
      ALU_NOT: alu_res = ~alu_e1;
      ALU_ADD: alu_res = alu_e1 + alu_e2;
      ALU_SUB: alu_res = alu_e1 - alu_e2;
      ALU_MUL: alu_res = alu_e1 * alu_e2;
      ALU_DIV: alu_res = (alu_e2 != 32'd0) ? alu_e1 / alu_e2 : 32'd0;
      ALU_SHL: alu_res = alu_e1 << alu_e2[4:0];
      ALU_EQ:  alu_res = (alu_e1 == alu_e2) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
    alu_zf = (alu_res == 32'd0);
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_valid"}, coef_valid, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_err"}, err, 0);
    check_val({tag, "_k"}, coef_k, 0);
    check_val({tag, "_coef"}, coef_out, 0);
    check_val({tag, "_e1"}, alu_e1, 0);
    check_val({tag, "_e2"}, alu_e2, 0);
    check_val({tag, "_sel"}, alu_sel, 0);
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low 10 cycles at k=2
  task automatic run_seq(input int n, input int mode);
    int idx = 0, cyc = 0, last_acc = -1, stall = 0, ndone = 0;
    longint sum = 0;
    bit prev_valid = 1'b0, fin = 1'b0;
    longint held = -1;
    @(negedge clk);
    start = 1'b1; n_in = NW'(n);
    coef_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; n_in = '0;
    cyc = 1;
    while (!fin && cyc < 3000) begin
      check_val("no_err", err, 0);
      if (coef_valid) begin
        if (idx == 0 && !prev_valid) check_val("first_lat", cyc, 1);
        if (mode == 0 && idx > 0 && !prev_valid) check_val("gap6", cyc - last_acc, 6);
        check_val("busy_in_emit", busy, 1);
        check_val("coef_k", coef_k, idx);
        check_val("coef_val", coef_out, pas[n][idx]);
        if (n == 30 && idx == 15) check_val("c30_15", coef_out, 155117520);
        if (prev_valid && held >= 0) check_val("held", coef_out, held);
        held = coef_out;
      end else begin
        held = -1;
      end
      case (mode)
        0: coef_ready = 1'b1;
        1: coef_ready = ($urandom_range(0, 2) != 0);
        default: coef_ready = !(idx == 2 && stall < 10);
      endcase
      if (coef_valid && !coef_ready) stall++;
      if (coef_valid && coef_ready) begin
        sum += coef_out;
        last_acc = cyc;
        idx++;
      end
      if (done) begin
        ndone++;
        check_val("done_lat", cyc - last_acc, 2);
        check_val("ncoef", idx, n + 1);
        @(negedge clk);
        check_val("done_pulse", done, 0);
        check_val("busy_after", busy, 0);
        fin = 1'b1;
      end else begin
        prev_valid = coef_valid;
        @(negedge clk);
        cyc++;
      end
    end
    coef_ready = 1'b0;
    check_val("seq_finished", fin, 1);
    check_val("ndone", ndone, 1);
    check_val("sum_pow2", sum, longint'(1) << n);
    if (mode == 2) check_val("stall_len", stall, 10);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) pas[i][j] = 0;
      pas[i][0] = 1;
      for (int j = 1; j <= i; j++) pas[i][j] = pas[i-1][j-1] + pas[i-1][j];
    end

    // reset state
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    run_seq(4, 0);
    run_seq(0, 0);
    run_seq(30, 0);
    run_seq(5, 2);

    // n above the limit is rejected with a single err pulse
    @(negedge clk);
    start = 1'b1; n_in = 5'd31;
    @(negedge clk);
    start = 1'b0; n_in = '0;
    check_val("err_pulse", err, 1);
    check_val("err_busy", busy, 0);
    check_val("err_valid", coef_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("err_once", err, 0);
      check_val("err_novalid", coef_valid, 0);
      check_val("err_nobusy", busy, 0);
    end

    for (int r = 0; r < 6; r++) run_seq($urandom_range(0, 30), 1);

    // second start during busy is ignored; async reset mid-run
    @(negedge clk);
    start = 1'b1; n_in = 5'd10; coef_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; n_in = '0;
    for (int i = 1; i < 20; i++) begin
      check_val("mid_busy", busy, 1);
      if (coef_valid) check_val("mid_coef", coef_out, pas[10][coef_k]);
      start = (i == 5);
      n_in  = (i == 5) ? 5'd3 : 5'd0;
      @(negedge clk);
    end
    start = 1'b1; n_in = 5'd3;
    rst = 1'b1;
    #1;
    check_quiet("async_rst");
    @(negedge clk);
    start = 1'b0; n_in = '0; coef_ready = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("post_rst");
    end

    run_seq(6, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_binom_coef_seq
